mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 154 +++++++++++++++
 tb/tb_mult_div_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// mult_div_unit: 32-bit signed multiply (radix-2 Booth) and divide (restoring),
// one result bit per cycle; results land in HI/LO on the Done cycle.
module mult_div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        MULT_OP,
  input  logic        DIV_OP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULT_RUN = 2'd1,
    DIV_RUN  = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t      state;
  logic [4:0]  count;
  logic        op_q;
  logic [31:0] opnd;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic        acc_qm1;
  logic        neg_q;
  logic        neg_r;

  logic        start;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  assign start = (state == IDLE) && (MULT_OP || DIV_OP) && !op_q;
  assign abs_a = A[31] ? -A : A;
  assign abs_b = B[31] ? -B : B;

  // Booth step: the 33-bit sum keeps the -2^31 multiplicand exact before the shift.
  logic [32:0] booth_sum;
  logic [31:0] booth_hi;
  logic [31:0] booth_lo;
  logic        booth_qm1;

  always_comb begin
    booth_sum = {acc_hi[31], acc_hi};
    case ({acc_lo[0], acc_qm1})
      2'b01:   booth_sum = {acc_hi[31], acc_hi} + {opnd[31], opnd};
      2'b10:   booth_sum = {acc_hi[31], acc_hi} - {opnd[31], opnd};
      default: booth_sum = {acc_hi[31], acc_hi};
    endcase
    booth_hi  = booth_sum[32:1];
    booth_lo  = {booth_sum[0], acc_lo[31:1]};
    booth_qm1 = acc_lo[0];
  end

  // Restoring step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  logic [32:0] trial;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  always_comb begin
    trial    = {acc_hi, acc_lo[31]} - {1'b0, opnd};
    div_hi   = trial[32] ? {acc_hi[30:0], acc_lo[31]} : trial[31:0];
    div_lo   = {acc_lo[30:0], ~trial[32]};
    quot_fix = neg_q ? -div_lo : div_lo;
    rem_fix  = neg_r ? -div_hi : div_hi;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      count   <= 5'd0;
      op_q    <= 1'b0;
      opnd    <= 32'd0;
      acc_hi  <= 32'd0;
      acc_lo  <= 32'd0;
      acc_qm1 <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      op_q <= MULT_OP | DIV_OP;
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count   <= 5'd0;
            DivZero <= 1'b0;
            if (MULT_OP) begin
              opnd    <= A;
              acc_hi  <= 32'd0;
              acc_lo  <= B;
              acc_qm1 <= 1'b0;
              state   <= MULT_RUN;
              Busy    <= 1'b1;
            end else if (B == 32'd0) begin
              state   <= DONE;
              Done    <= 1'b1;
              DivZero <= 1'b1;
            end else begin
              opnd   <= abs_b;
              acc_hi <= 32'd0;
              acc_lo <= abs_a;
              neg_q  <= A[31] ^ B[31];
              neg_r  <= A[31];
              state  <= DIV_RUN;
              Busy   <= 1'b1;
            end
          end
        end
        MULT_RUN: begin
          acc_hi  <= booth_hi;
          acc_lo  <= booth_lo;
          acc_qm1 <= booth_qm1;
          count   <= count + 5'd1;
          if (count == 5'd31) begin
            HI    <= booth_hi;
            LO    <= booth_lo;
            state <= DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end
        end
        DIV_RUN: begin
          acc_hi <= div_hi;
          acc_lo <= div_lo;
          count  <= count + 5'd1;
          if (count == 5'd31) begin
            HI    <= rem_fix;
            LO    <= quot_fix;
            state <= DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// tb_mult_div_unit: randomized and directed checks of mult_div_unit against
// a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        MULT_OP = 1'b0;
  logic        DIV_OP = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;
  logic        Done;
  logic        DivZero;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mult_div_unit dut (
    .clock   (clock),
    .reset   (reset),
    .MULT_OP (MULT_OP),
    .DIV_OP  (DIV_OP),
    .A       (A),
    .B       (B),
    .HI      (HI),
    .LO      (LO),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Signed 64-bit arithmetic gives the exact product, and truncating division
  // with a dividend-signed remainder; the low 32 bits are the wrapped result.
  task automatic model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output bit dz);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    if (is_mult) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      dz = 1'b1;
      hi = exp_hi;
      lo = exp_lo;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endtask

  task automatic do_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    logic [31:0] ehi, elo;
    bit edz;
    int k, busy_bad;
    model(m, a, b, ehi, elo, edz);
    @(negedge clock);
    A = a; B = b; MULT_OP = m; DIV_OP = d;
    k = 0;
    busy_bad = 0;
    do begin
      @(negedge clock);
      k++;
      if (k == 1) begin
        MULT_OP = 1'b0; DIV_OP = 1'b0;
        A = $urandom; B = $urandom;
      end
      if (!Done && Busy !== 1'b1) busy_bad++;
    end while (!Done && k < 40);
    check({tag, " latency"}, 64'(k), edz ? 64'd1 : 64'd33);
    check({tag, " busy"}, 64'(busy_bad), 64'd0);
    check({tag, " HI"}, {32'd0, HI}, {32'd0, ehi});
    check({tag, " LO"}, {32'd0, LO}, {32'd0, elo});
    check({tag, " DivZero"}, {63'd0, DivZero}, {63'd0, edz});
    @(negedge clock);
    check({tag, " pulse"}, {62'd0, Done, Busy}, 64'd0);
    check({tag, " hold"}, {HI, LO}, {ehi, elo});
    exp_hi = ehi;
    exp_lo = elo;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    bit m;
    repeat (3) @(negedge clock);
    check("reset HI/LO", {HI, LO}, 64'd0);
    check("reset flags", {61'd0, Busy, Done, DivZero}, 64'd0);
    reset = 1'b0;

    do_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, "mul 7*-3");
    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, "div -7/2");
    do_op(1'b0, 1'b1, 32'd5, 32'd0, "div by zero");
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1");
    do_op(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, "both ops min*min");

    // A level held across the whole operation must produce exactly one result.
    @(negedge clock);
    A = 32'd3; B = 32'd5; MULT_OP = 1'b1;
    pulses = 0;
    repeat (45) begin
      @(negedge clock);
      if (Done) pulses++;
    end
    check("held level pulses", 64'(pulses), 64'd1);
    check("held level result", {HI, LO}, 64'd15);
    exp_hi = 32'd0; exp_lo = 32'd15;
    MULT_OP = 1'b0;
    do_op(1'b1, 1'b0, 32'd11, 32'd13, "rerise");

    // Abort a multiply with reset mid-run.
    @(negedge clock);
    A = 32'd100; B = 32'd200; MULT_OP = 1'b1;
    @(negedge clock);
    MULT_OP = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort HI/LO", {HI, LO}, 64'd0);
    check("abort flags", {62'd0, Busy, Done}, 64'd0);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (Done) pulses++;
    end
    check("abort no done", 64'(pulses), 64'd0);
    exp_hi = 32'd0; exp_lo = 32'd0;

    // A request level present through reset starts right after release.
    @(negedge clock);
    reset = 1'b1; A = 32'd6; B = 32'd7; MULT_OP = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post-reset start", {63'd0, Busy}, 64'd1);
    MULT_OP = 1'b0;
    pulses = 0;
    while (!Done && pulses < 40) begin
      @(negedge clock);
      pulses++;
    end
    check("post-reset result", {HI, LO}, 64'd42);
    exp_hi = 32'd0; exp_lo = 32'd42;
    @(negedge clock);

    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      do_op(m, ~m | 1'($urandom_range(0, 1)), pick(), pick(), m ? "rand mul" : "rand div");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
